// File: rtl/reg_bank_wb_pkg.sv
// Shared types and constants for the register bank / write-back buffer.
package reg_bank_wb_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = $clog2(NREGS);

  // Width of one register slice inside regs_flat; register i sits at reg_lsb(i).
  localparam int REG_SLICE_W = DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic int reg_lsb(input int idx);
    return idx * REG_SLICE_W;
  endfunction

endpackage

// File: rtl/reg_bank_wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back entries. No bypass: a pushed entry
// is visible at the head only from the following cycle.
module wb_fifo
  import reg_bank_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  wb_entry_t                din_i,
  input  logic                     pop_i,
  output wb_entry_t                dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow locally so the FIFO is safe on its own.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  // Storage needs no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_bank_wb.sv
// reg_bank_wb: sixteen architectural registers fed by a write-back FIFO, with
// a per-register busy scoreboard. All outputs come straight from flops.
// Optional: define REG_BANK_ZERO_REG_EN to hardwire register 0 to zero.
module reg_bank_wb
  import reg_bank_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic                          rsv_valid,
  input  logic [ADDR_W-1:0]             rsv_addr,
  input  logic                          freeze,
  output logic [NREGS*DATA_W-1:0]       regs_flat,
  output logic [NREGS-1:0]              busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]             busy_q, busy_d;
  wb_entry_t                    wr_entry, head;
  logic                         full, empty, push, pop;

  assign wr_entry.addr = wb_addr;
  assign wr_entry.data = wb_data;

  // Ready looks only at the registered full flag; a same-cycle pop does not
  // open a slot, which keeps wb_valid -> wb_ready free of combinational paths.
  assign wb_ready = !full;
  assign push     = wb_valid && !full;
  assign pop      = !empty && !freeze;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (wr_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  // Commit the FIFO head into the register array.
  always_comb begin
    regs_d = regs_q;
    if (pop) regs_d[head.addr] = head.data;
`ifdef REG_BANK_ZERO_REG_EN
    regs_d[0] = '0;
`endif
  end

  // Scoreboard: commit clears, reservation sets; set applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (pop)       busy_d[head.addr] = 1'b0;
    if (rsv_valid) busy_d[rsv_addr]  = 1'b1;
`ifdef REG_BANK_ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
  end

  // Register array and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign regs_flat = regs_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: reset, latency, freeze/backpressure,
// back-to-back writes, scoreboard set/clear conflict, register 0, mid-run reset.
module tb_reg_bank_wb;
  import reg_bank_wb_pkg::*;

  localparam int FIFO_DEPTH = 2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      wb_valid, wb_ready;
  logic [ADDR_W-1:0]         wb_addr;
  logic [DATA_W-1:0]         wb_data;
  logic                      rsv_valid;
  logic [ADDR_W-1:0]         rsv_addr;
  logic                      freeze;
  logic [NREGS*DATA_W-1:0]   regs_flat;
  logic [NREGS-1:0]          busy;
  logic [CW-1:0]             fifo_count;

  int n_chk = 0;
  int n_err = 0;
  logic [DATA_W-1:0] mdl [NREGS];

  reg_bank_wb #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .freeze     (freeze),
    .regs_flat  (regs_flat),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NREGS*DATA_W-1:0] mdl_flat();
    logic [NREGS*DATA_W-1:0] f;
    for (int i = 0; i < NREGS; i++) f[reg_lsb(i) +: DATA_W] = mdl[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; freeze = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    // Reset / idle
    chk("rst_regs",  regs_flat,  '0);
    chk("rst_busy",  busy,       '0);
    chk("rst_ready", wb_ready,   1'b1);
    chk("rst_count", fifo_count, '0);

    // Reserve r5, then write r5 = BEEF two cycles later
    rsv_valid = 1'b1; rsv_addr = 4'd5;
    tick();
    rsv_valid = 1'b0;
    chk("busy5_c1", busy, 16'h0020);
    tick();
    chk("busy5_c2", busy, 16'h0020);
    drive_wr(4'd5, 16'hBEEF);
    tick();
    wb_valid = 1'b0;
    chk("busy5_c3",   busy,       16'h0020);
    chk("cnt_after_enq", fifo_count, 2'd1);
    chk("r5_not_yet", regs_flat,  mdl_flat());
    tick();
    mdl[5] = 16'hBEEF;
    chk("r5_commit",  regs_flat,  mdl_flat());
    chk("busy5_clr",  busy,       16'h0000);
    chk("cnt_drain",  fifo_count, 2'd0);

    // Freeze with three writes: third sees full, then in-order drain
    freeze = 1'b1;
    drive_wr(4'd1, 16'd1);
    tick();
    chk("frz_ready1", wb_ready, 1'b1);
    drive_wr(4'd2, 16'd2);
    tick();
    chk("frz_cnt2",   fifo_count, 2'd2);
    chk("frz_ready0", wb_ready,   1'b0);
    drive_wr(4'd3, 16'd3);
    tick();
    chk("frz_held_cnt",  fifo_count, 2'd2);
    chk("frz_no_commit", regs_flat,  mdl_flat());
    freeze = 1'b0;
    tick();
    mdl[1] = 16'd1;
    chk("drain_r1",     regs_flat,  mdl_flat());
    chk("drain_r1_cnt", fifo_count, 2'd1);
    tick();
    wb_valid = 1'b0;
    mdl[2] = 16'd2;
    chk("drain_r2",     regs_flat,  mdl_flat());
    chk("drain_r2_cnt", fifo_count, 2'd1);
    tick();
    mdl[3] = 16'd3;
    chk("drain_r3",     regs_flat,  mdl_flat());
    chk("drain_r3_cnt", fifo_count, 2'd0);

    // Back-to-back writes at one per cycle
    drive_wr(4'd11, 16'hA0A0);
    tick();
    drive_wr(4'd12, 16'hB1B1);
    tick();
    chk("b2b_cnt",   fifo_count, 2'd1);
    chk("b2b_ready", wb_ready,   1'b1);
    mdl[11] = 16'hA0A0;
    chk("b2b_r11",   regs_flat,  mdl_flat());
    drive_wr(4'd13, 16'hC2C2);
    tick();
    wb_valid = 1'b0;
    tick();
    mdl[12] = 16'hB1B1; mdl[13] = 16'hC2C2;
    chk("b2b_all",     regs_flat,  mdl_flat());
    chk("b2b_cnt_end", fifo_count, 2'd0);

    // Same-cycle reserve and commit of r7: set wins
    drive_wr(4'd7, 16'h0077);
    tick();
    wb_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 4'd7;
    tick();
    rsv_valid = 1'b0;
    mdl[7] = 16'h0077;
    chk("conflict_busy", busy,      16'h0080);
    chk("conflict_r7",   regs_flat, mdl_flat());

    // Register 0 write and reserve
    drive_wr(4'd0, 16'h1234);
    tick();
    wb_valid = 1'b0;
    tick();
`ifndef REG_BANK_ZERO_REG_EN
    mdl[0] = 16'h1234;
`endif
    chk("r0_write", regs_flat,  mdl_flat());
    chk("r0_cnt",   fifo_count, 2'd0);
    rsv_valid = 1'b1; rsv_addr = 4'd0;
    tick();
    rsv_valid = 1'b0;
`ifdef REG_BANK_ZERO_REG_EN
    chk("r0_busy", busy, 16'h0080);
`else
    chk("r0_busy", busy, 16'h0081);
`endif

    // Mid-run reset with two buffered entries
    freeze = 1'b1;
    drive_wr(4'd9, 16'h0009);
    tick();
    drive_wr(4'd10, 16'h000A);
    tick();
    wb_valid = 1'b0;
    chk("pre_rst_cnt", fifo_count, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    chk("arst_ready", wb_ready,   1'b1);
    chk("arst_count", fifo_count, 2'd0);
    chk("arst_regs",  regs_flat,  '0);
    chk("arst_busy",  busy,       '0);
    freeze = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_regs", regs_flat,  mdl_flat());
    chk("post_rst_cnt",  fifo_count, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_wb.md
# reg_bank_wb

Register bank and write-back buffer that sits directly upstream of the 16:1 operand-select mux. It holds sixteen 16-bit architectural registers and drives all of them in parallel as the mux's in0..in15. Writes arrive from the write-back stage through a valid/ready handshake and pass through a small FIFO before commit. A per-register busy scoreboard tells the issue stage which registers have writes outstanding.

## Interface
Parameters:
- DATA_W, 16, register width.
- NREGS, 16, register count; address width ADDR_W = $clog2(NREGS) = 4.
- FIFO_DEPTH, 2, write-back buffer entries; legal values are 2 and 4.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset. Assertion is asynchronous; deassertion is sampled on clk.
- wb_valid, in, 1, write-back request valid.
- wb_ready, out, 1, buffer can accept a request; equals !full.
- wb_addr, in, ADDR_W, destination register.
- wb_data, in, DATA_W, write data.
- rsv_valid, in, 1, issue stage reserves a destination register.
- rsv_addr, in, ADDR_W, register to mark busy.
- freeze, in, 1, while high, FIFO head commit is inhibited. Enqueue still proceeds.
- regs_flat, out, NREGS*DATA_W, register contents. Register i is at bits [DATA_W*i+DATA_W-1 : DATA_W*i] and feeds mux input in_i.
- busy, out, NREGS, scoreboard; bit i is set while a write to register i is outstanding.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, number of occupied FIFO entries.

## Operation
- Enqueue: a request enqueues on a rising edge when wb_valid && wb_ready. The FIFO stores {addr, data}.
- Commit: on a rising edge, if the FIFO is non-empty and !freeze, the head entry is written to register[head.addr] and popped. One commit per cycle.
- Same-cycle enqueue and commit on a full FIFO:
  - wb_ready is computed from the current full flag only.
  - A pop in the same cycle does not allow the full FIFO to accept a request. There is no combinational ready path.
- Scoreboard set: rsv_valid sets busy[rsv_addr].
- Scoreboard clear: a commit clears busy[head.addr].
- Scoreboard conflict: if a set and a clear hit the same register in the same cycle, the set wins and the bit stays 1.
- Reserving an already-busy register is idempotent. There is no count.
- FIFO pointers wrap modulo FIFO_DEPTH.
- A write with wb_valid while the FIFO is full is held by the producer; no data is lost.
- Reset state:
  - All registers are 0.
  - busy is 0.
  - FIFO is empty: fifo_count = 0, wb_ready = 1.
  - Reset mid-operation discards all buffered writes, including any in-flight commit that has not yet reached an edge.

## Timing
- Write latency when not frozen: data enqueued at edge N is visible on regs_flat after edge N+1. busy clears at the same edge N+1.
- While freeze is held, latency extends by the number of frozen cycles.
- Back-to-back writes sustain one per cycle with FIFO_DEPTH ≥ 2 when not frozen.
- regs_flat, busy, fifo_count and wb_ready are all registered outputs or decoded directly from flops. None of them depend combinationally on wb_valid, rsv_valid or freeze.
- busy is set at the edge that samples rsv_valid, so it is visible the following cycle.

## Configuration
- Macro REG_BANK_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to 0 and regs_flat[DATA_W-1:0] is constant 0.
  - Commits to address 0 are dropped. The entry is still popped.
  - rsv_valid to address 0 is ignored, so busy[0] is constant 0.
- Undefined: register 0 behaves like every other register.

## Structure
- A shared package holds:
  - DATA_W, NREGS, ADDR_W.
  - wb_entry_t, a packed struct {addr, data}.
  - The regs_flat slice helper constant.
- One sub-module, wb_fifo. It is a synchronous FIFO of wb_entry_t with push/pop, full, empty and count; it has no bypass path.
- The scoreboard and register array live in reg_bank_wb.

## Test plan
- Reset then idle: regs_flat = 0, busy = 0, wb_ready = 1, fifo_count = 0.
- rsv r5 at cycle 0; write r5 = 0xBEEF at cycle 2.
  - busy[5] is 1 from cycle 1 to cycle 3.
  - reg5 = 0xBEEF and busy[5] = 0 after edge 3.
- Hold freeze and issue 3 writes (r1 = 1, r2 = 2, r3 = 3) with FIFO_DEPTH = 2:
  - The third request sees wb_ready = 0 with fifo_count = 2.
  - After releasing freeze, r1 commits, then r2, then r3.
- Same-cycle rsv r7 and commit of r7: busy[7] stays 1.
- With REG_BANK_ZERO_REG_EN, write r0 = 0x1234: reg0 stays 0 and fifo_count returns to 0. Without the macro, reg0 = 0x1234.
- Assert rst_n low with 2 entries buffered: immediately wb_ready = 1, fifo_count = 0 and all registers are 0. No buffered write commits after release.
